// File: rtl/memory_stage.sv
// MIPS MEM stage: branch/jump resolution, req/ack data-memory access,
// MEM/WB pipeline register and MEM/WB forwarding sources.
module memory_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              branch,
  input  logic              jump,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] add_in,
  input  logic              aluzero,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] readdata2_in,
  input  logic [REG_W-1:0]  regrd_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              pcsrc,
  output logic              jump_out,
  output logic [DATA_W-1:0] branch_target,
  output logic [REG_W-1:0]  MEMRegRd,
  output logic              MEM_RegWrite,
  output logic [DATA_W-1:0] regExMem,
  output logic [REG_W-1:0]  WBRegRd,
  output logic              WB_RegWrite,
  output logic              WB_MemtoReg,
  output logic [DATA_W-1:0] wb_readdata,
  output logic [DATA_W-1:0] wb_aluout,
  output logic [DATA_W-1:0] regMemWb,
  output logic              align_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              wb_rw_q, wb_rw_d;
  logic              wb_m2r_q, wb_m2r_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
  logic [DATA_W-1:0] wb_alu_q, wb_alu_d;

  logic memop;
  logic misalign;

  assign memop    = MemRead | MemWrite;
  assign misalign = memop & (alu_in[1:0] != 2'b00);

  // Stall covers the issue cycle and every WAIT cycle; DONE lets EX/MEM advance.
  assign stall = ((state_q == IDLE) & memop & ~misalign)
               | (state_q == WAIT);

  assign pcsrc         = branch & aluzero & ~stall;
  assign jump_out      = jump & ~stall;
  assign branch_target = add_in;
  assign MEMRegRd      = regrd_in;
  assign MEM_RegWrite  = RegWrite & ~MemtoReg;
  assign regExMem      = alu_in;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wb_rw_d    = 1'b0;
    wb_m2r_d   = 1'b0;
    wb_rd_d    = '0;
    wb_rdata_d = '0;
    wb_alu_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (!memop) begin
          wb_rw_d  = RegWrite;
          wb_alu_d = alu_in;
          wb_rd_d  = regrd_in;
        end else if (misalign) begin
          err_d = 1'b1;
        end else begin
          req_d   = 1'b1;
          we_d    = MemWrite;
          addr_d  = alu_in;
          wdata_d = readdata2_in;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = dmem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_rw_d    = RegWrite;
        wb_m2r_d   = MemtoReg;
        wb_rdata_d = rdata_q;
        wb_alu_d   = alu_in;
        wb_rd_d    = regrd_in;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_rdata_q <= '0;
      wb_alu_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wb_rw_q    <= wb_rw_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rd_q    <= wb_rd_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign align_err   = err_q;
  assign WBRegRd     = wb_rd_q;
  assign WB_RegWrite = wb_rw_q;
  assign WB_MemtoReg = wb_m2r_q;
  assign wb_readdata = wb_rdata_q;
  assign wb_aluout   = wb_alu_q;
  assign regMemWb    = wb_m2r_q ? wb_rdata_q : wb_alu_q;

endmodule

// File: doc/memory_stage.md
# memory_stage

MIPS pipeline MEM stage: consumer of the EX/MEM register outputs produced by the execute stage. Resolves branch/jump redirection, performs loads/stores through a request/acknowledge data-memory port with multi-cycle latency, stalls the front of the pipeline while a memory access is outstanding, and owns the MEM/WB pipeline register plus the MEM- and WB-side forwarding sources consumed by the forwarding unit.

## Interface
- DATA_W, 32, data/address width
- REG_W, 5, register-index width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- branch, jump, MemRead, MemWrite, RegWrite, MemtoReg  in  1 each  EX/MEM control
- add_in  in  DATA_W  branch target from EX/MEM
- aluzero  in  1  ALU zero flag
- alu_in  in  DATA_W  ALU result / memory address
- readdata2_in  in  DATA_W  store data
- regrd_in  in  REG_W  destination register
- dmem_req  out  1  registered request
- dmem_we  out  1  registered write enable
- dmem_addr  out  DATA_W  registered address
- dmem_wdata  out  DATA_W  registered store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- pcsrc  out  1  take branch: branch & aluzero & ~stall
- jump_out  out  1  jump & ~stall
- branch_target  out  DATA_W  = add_in
- MEMRegRd  out  REG_W  = regrd_in
- MEM_RegWrite  out  1  = RegWrite & ~MemtoReg (load data not forwardable from MEM)
- regExMem  out  DATA_W  = alu_in
- WBRegRd  out  REG_W  MEM/WB destination
- WB_RegWrite  out  1  MEM/WB register-write enable
- WB_MemtoReg  out  1  MEM/WB select
- wb_readdata, wb_aluout  out  DATA_W  MEM/WB data fields
- regMemWb  out  DATA_W  WB_MemtoReg ? wb_readdata : wb_aluout
- align_err  out  1  sticky misaligned-access flag

## Operation
- memop = MemRead | MemWrite; misalign = memop & (alu_in[1:0] != 0).
- FSM states IDLE, WAIT, DONE.
- IDLE, no memop: stall=0; MEM/WB loads {RegWrite, MemtoReg=0, alu_in, regrd_in} at edge.
- IDLE, misalign: no request; stall=0; MEM/WB loads bubble (WB_RegWrite=0); align_err<=1; stay IDLE.
- IDLE, memop aligned: stall=1; at edge dmem_req<=1, dmem_we<=MemWrite, dmem_addr<=alu_in, dmem_wdata<=readdata2_in; MEM/WB loads bubble; ->WAIT.
- WAIT: stall=1; dmem_* held stable; MEM/WB loads bubble each edge. On dmem_ack: dmem_req<=0, dmem_we<=0, internal rdata_q<=dmem_rdata; ->DONE.
- DONE: stall=0; no new request; MEM/WB loads {RegWrite, MemtoReg, rdata_q, alu_in, regrd_in} (store: RegWrite=0 from EX/MEM); ->IDLE unconditionally.
- dmem_ack ignored outside WAIT.
- Bubble = WB_RegWrite=0, WB_MemtoReg=0, WBRegRd=0, data fields 0.

## Timing
- Reset: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, all MEM/WB fields, rdata_q, align_err = 0.
- RST during WAIT: request dropped at that edge; in-flight access abandoned; late dmem_ack ignored.
- ALU/branch instruction: 1 cycle in MEM; result in MEM/WB next cycle.
- Memory op: 1 (IDLE) + N (WAIT, N>=1, ack cycle included) + 1 (DONE) cycles; stall high for N+1 cycles.
- dmem_req rises the edge after memop seen, falls the edge after ack sampled.
- Back-to-back memops: DONE->IDLE then new request issued one cycle later; no request ever overlaps.
- pcsrc, jump_out, MEM forwarding outputs combinational from EX/MEM inputs; WB outputs registered.

## Test plan
- Reset then add (RegWrite=1, alu_in=0x0000_0010, regrd_in=5) -> next cycle WBRegRd=5, WB_RegWrite=1, regMemWb=0x10; stall never high.
- Load alu_in=0x100, ack 3 cycles after req -> dmem_req high 3 cycles, stall high 4 cycles, then regMemWb=dmem_rdata (0xDEADBEEF), WB_MemtoReg=1, WBRegRd correct for exactly one cycle.
- Store alu_in=0x204, readdata2_in=0x1234 -> dmem_we=1, dmem_wdata=0x1234, dmem_addr=0x204 stable until ack; WB_RegWrite=0 throughout.
- Branch with aluzero=1, add_in=0x40 -> pcsrc=1, branch_target=0x40 same cycle; aluzero=0 -> pcsrc=0.
- Load at alu_in=0x102 -> no dmem_req, bubble in MEM/WB, align_err=1 and stays 1 until RST.
- RST asserted in WAIT, ack arrives next cycle -> dmem_req=0 after edge, state IDLE, MEM/WB unchanged by ack, stall=0.
